// File: rtl/control_pkg.sv
// Shared opcode, control-bit and control-word definitions for the 8-bit computer
// microcode sequencer.
package control_pkg;

  typedef logic [15:0] ctrl_word_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CB_HLT = 15;
  localparam int CB_MI  = 14;
  localparam int CB_RI  = 13;
  localparam int CB_RO  = 12;
  localparam int CB_IO  = 11;
  localparam int CB_II  = 10;
  localparam int CB_AI  = 9;
  localparam int CB_AO  = 8;
  localparam int CB_EO  = 7;
  localparam int CB_SU  = 6;
  localparam int CB_BI  = 5;
  localparam int CB_OI  = 4;
  localparam int CB_CE  = 3;
  localparam int CB_CO  = 2;
  localparam int CB_J   = 1;
  localparam int CB_FI  = 0;

  localparam ctrl_word_t CW_HLT = ctrl_word_t'(1) << CB_HLT;
  localparam ctrl_word_t CW_MI  = ctrl_word_t'(1) << CB_MI;
  localparam ctrl_word_t CW_RI  = ctrl_word_t'(1) << CB_RI;
  localparam ctrl_word_t CW_RO  = ctrl_word_t'(1) << CB_RO;
  localparam ctrl_word_t CW_IO  = ctrl_word_t'(1) << CB_IO;
  localparam ctrl_word_t CW_II  = ctrl_word_t'(1) << CB_II;
  localparam ctrl_word_t CW_AI  = ctrl_word_t'(1) << CB_AI;
  localparam ctrl_word_t CW_AO  = ctrl_word_t'(1) << CB_AO;
  localparam ctrl_word_t CW_EO  = ctrl_word_t'(1) << CB_EO;
  localparam ctrl_word_t CW_SU  = ctrl_word_t'(1) << CB_SU;
  localparam ctrl_word_t CW_BI  = ctrl_word_t'(1) << CB_BI;
  localparam ctrl_word_t CW_OI  = ctrl_word_t'(1) << CB_OI;
  localparam ctrl_word_t CW_CE  = ctrl_word_t'(1) << CB_CE;
  localparam ctrl_word_t CW_CO  = ctrl_word_t'(1) << CB_CO;
  localparam ctrl_word_t CW_J   = ctrl_word_t'(1) << CB_J;
  localparam ctrl_word_t CW_FI  = ctrl_word_t'(1) << CB_FI;

  localparam ctrl_word_t CW_FETCH0 = CW_CO | CW_MI;
  localparam ctrl_word_t CW_FETCH1 = CW_RO | CW_II | CW_CE;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: (step, opcode, flags) -> control word plus the index
// of the last non-empty step of that opcode.
module microcode_rom
  import control_pkg::*;
(
  input  logic       [2:0] i_step,
  input  logic       [3:0] i_instr,
  input  logic             i_flag_c,
  input  logic             i_flag_z,
  output ctrl_word_t       o_ctrl_word,
  output logic       [2:0] o_last_step
);

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    o_ctrl_word = '0;
    o_last_step = 3'd1;
    if (i_step == 3'd0) begin
      o_ctrl_word = CW_FETCH0;
    end else if (i_step == 3'd1) begin
      o_ctrl_word = CW_FETCH1;
    end
    case (i_instr)
      OP_LDA: begin
        o_last_step = 3'd3;
        if (i_step == 3'd2) o_ctrl_word = CW_IO | CW_MI;
        if (i_step == 3'd3) o_ctrl_word = CW_RO | CW_AI;
      end
      OP_ADD, OP_SUB: begin
        o_last_step = 3'd4;
        if (i_step == 3'd2) o_ctrl_word = CW_IO | CW_MI;
        if (i_step == 3'd3) o_ctrl_word = CW_RO | CW_BI;
        if (i_step == 3'd4) begin
          o_ctrl_word = CW_EO | CW_AI | CW_FI | ((i_instr == OP_SUB) ? CW_SU : '0);
        end
      end
      OP_STA: begin
        o_last_step = 3'd3;
        if (i_step == 3'd2) o_ctrl_word = CW_IO | CW_MI;
        if (i_step == 3'd3) o_ctrl_word = CW_AO | CW_RI;
      end
      OP_LDI: begin
        o_last_step = 3'd2;
        if (i_step == 3'd2) o_ctrl_word = CW_IO | CW_AI;
      end
      OP_JMP: begin
        o_last_step = 3'd2;
        if (i_step == 3'd2) o_ctrl_word = CW_IO | CW_J;
      end
      // Conditional jumps always reach T2; flags only matter in that step.
      OP_JC: begin
        o_last_step = 3'd2;
        if (i_step == 3'd2 && i_flag_c) o_ctrl_word = CW_IO | CW_J;
      end
      OP_JZ: begin
        o_last_step = 3'd2;
        if (i_step == 3'd2 && i_flag_z) o_ctrl_word = CW_IO | CW_J;
      end
      OP_OUT: begin
        o_last_step = 3'd2;
        if (i_step == 3'd2) o_ctrl_word = CW_AO | CW_OI;
      end
      OP_HLT: begin
        o_last_step = 3'd2;
        if (i_step == 3'd2) o_ctrl_word = CW_HLT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Micro-step counter and halt latch around the microcode ROM; emits the control
// word the datapath samples on the next rising clk edge.
module control_sequencer
  import control_pkg::*;
#(
  parameter int NUM_STEPS = 5,
  parameter bit EARLY_END = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  instr,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic [15:0] ctrl_word,
  output logic [2:0]  step,
  output logic        halted
);

  localparam logic [2:0] LP_FINAL_STEP = 3'(NUM_STEPS - 1);

  logic       [2:0] r_step;
  logic             r_halted;
  ctrl_word_t       w_rom_word;
  logic       [2:0] w_last_step;
  logic             w_step_end;

  microcode_rom u_rom (
    .i_step      (r_step),
    .i_instr     (instr),
    .i_flag_c    (flag_c),
    .i_flag_z    (flag_z),
    .o_ctrl_word (w_rom_word),
    .o_last_step (w_last_step)
  );

  assign w_step_end = (r_step == LP_FINAL_STEP) || (EARLY_END && (r_step >= w_last_step));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_step   <= 3'd0;
      r_halted <= 1'b0;
    end else if (enable && !r_halted) begin
      // Halt wins over wrap so the counter freezes on the HLT step.
      if (w_rom_word[CB_HLT]) begin
        r_halted <= 1'b1;
      end else if (w_step_end) begin
        r_step <= 3'd0;
      end else begin
        r_step <= r_step + 3'd1;
      end
    end
  end

  assign ctrl_word = r_halted ? CW_HLT : w_rom_word;
  assign step      = r_step;
  assign halted    = r_halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench: one sequencer with EARLY_END=1 driven by a vector
// table, one with EARLY_END=0 exercised by full-length instruction runs.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset, enable, flag_c, flag_z;
  logic [3:0]  instr;
  logic [15:0] word_e, word_f;
  logic [2:0]  step_e, step_f;
  logic        halt_e, halt_f;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  control_sequencer #(.NUM_STEPS(5), .EARLY_END(1'b1)) dut_e (
    .clk(clk), .reset(reset), .enable(enable), .instr(instr),
    .flag_c(flag_c), .flag_z(flag_z),
    .ctrl_word(word_e), .step(step_e), .halted(halt_e)
  );

  control_sequencer #(.NUM_STEPS(5), .EARLY_END(1'b0)) dut_f (
    .clk(clk), .reset(reset), .enable(enable), .instr(instr),
    .flag_c(flag_c), .flag_z(flag_z),
    .ctrl_word(word_f), .step(step_f), .halted(halt_f)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  op;
    logic        c;
    logic        z;
    logic [2:0]  exp_step;
    logic [15:0] exp_word;
    logic        exp_halt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic en, input logic [3:0] op, input logic c,
                     input logic z, input logic [2:0] st, input logic [15:0] w, input logic h);
    vec_t v;
    v.rst = rst; v.en = en; v.op = op; v.c = c; v.z = z;
    v.exp_step = st; v.exp_word = w; v.exp_halt = h;
    vecs.push_back(v);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1; enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check({tag, " e step"}, 16'(step_e), 16'd0);
    check({tag, " e halted"}, 16'(halt_e), 16'd0);
    check({tag, " e word"}, word_e, 16'h4004);
    check({tag, " f step"}, 16'(step_f), 16'd0);
    check({tag, " f halted"}, 16'(halt_f), 16'd0);
    check({tag, " f word"}, word_f, 16'h4004);
  endtask

  // Full five-step run on the EARLY_END=0 instance, starting from a fresh reset.
  task automatic run_full(input string tag, input logic [3:0] op, input logic c,
                          input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] w4);
    logic [15:0] exp_w[5];
    exp_w[0] = 16'h4004; exp_w[1] = 16'h1408; exp_w[2] = w2; exp_w[3] = w3; exp_w[4] = w4;
    do_reset({tag, " reset"});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      enable = 1'b1; instr = op; flag_c = c; flag_z = 1'b0;
      #1;
      check($sformatf("%s T%0d step", tag, k), 16'(step_f), 16'(k));
      check($sformatf("%s T%0d word", tag, k), word_f, exp_w[k]);
    end
    @(negedge clk);
    #1;
    check({tag, " wrap step"}, 16'(step_f), 16'd0);
    check({tag, " wrap word"}, word_f, 16'h4004);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; instr = 4'h0; flag_c = 1'b0; flag_z = 1'b0;

    // LDA: 0,1,2,3 then back to 0
    add(0,1,4'h1,0,0, 3'd0,16'h4004,0);
    add(0,1,4'h1,0,0, 3'd1,16'h1408,0);
    add(0,1,4'h1,0,0, 3'd2,16'h4800,0);
    add(0,1,4'h1,0,0, 3'd3,16'h1200,0);
    // JC, carry high outside T2 but clear at T2: empty T2, then wrap
    add(0,1,4'h7,1,0, 3'd0,16'h4004,0);
    add(0,1,4'h7,1,0, 3'd1,16'h1408,0);
    add(0,1,4'h7,0,0, 3'd2,16'h0000,0);
    // JC taken
    add(0,1,4'h7,0,0, 3'd0,16'h4004,0);
    add(0,1,4'h7,0,0, 3'd1,16'h1408,0);
    add(0,1,4'h7,1,0, 3'd2,16'h0802,0);
    // JZ not taken, zero flag set only at T1
    add(0,1,4'h8,0,1, 3'd0,16'h4004,0);
    add(0,1,4'h8,0,1, 3'd1,16'h1408,0);
    add(0,1,4'h8,0,0, 3'd2,16'h0000,0);
    // JZ taken
    add(0,1,4'h8,0,0, 3'd0,16'h4004,0);
    add(0,1,4'h8,0,0, 3'd1,16'h1408,0);
    add(0,1,4'h8,0,1, 3'd2,16'h0802,0);
    // STA with enable low for 4 cycles at T3
    add(0,1,4'h4,0,0, 3'd0,16'h4004,0);
    add(0,1,4'h4,0,0, 3'd1,16'h1408,0);
    add(0,1,4'h4,0,0, 3'd2,16'h4800,0);
    add(0,0,4'h4,0,0, 3'd3,16'h2100,0);
    add(0,0,4'h4,0,0, 3'd3,16'h2100,0);
    add(0,0,4'h4,0,0, 3'd3,16'h2100,0);
    add(0,0,4'h4,0,0, 3'd3,16'h2100,0);
    add(0,1,4'h4,0,0, 3'd3,16'h2100,0);
    // undefined opcode: fetch only
    add(0,1,4'hA,0,0, 3'd0,16'h4004,0);
    add(0,1,4'hA,0,0, 3'd1,16'h1408,0);
    // LDI, OUT, JMP, NOP
    add(0,1,4'h5,0,0, 3'd0,16'h4004,0);
    add(0,1,4'h5,0,0, 3'd1,16'h1408,0);
    add(0,1,4'h5,0,0, 3'd2,16'h0A00,0);
    add(0,1,4'hE,0,0, 3'd0,16'h4004,0);
    add(0,1,4'hE,0,0, 3'd1,16'h1408,0);
    add(0,1,4'hE,0,0, 3'd2,16'h0110,0);
    add(0,1,4'h6,0,0, 3'd0,16'h4004,0);
    add(0,1,4'h6,0,0, 3'd1,16'h1408,0);
    add(0,1,4'h6,0,0, 3'd2,16'h0802,0);
    add(0,1,4'h0,0,0, 3'd0,16'h4004,0);
    add(0,1,4'h0,0,0, 3'd1,16'h1408,0);
    // ADD abandoned by reset at T3
    add(0,1,4'h2,0,0, 3'd0,16'h4004,0);
    add(0,1,4'h2,0,0, 3'd1,16'h1408,0);
    add(0,1,4'h2,0,0, 3'd2,16'h4800,0);
    add(1,1,4'h2,0,0, 3'd3,16'h1020,0);
    // HLT
    add(0,1,4'hF,0,0, 3'd0,16'h4004,0);
    add(0,1,4'hF,0,0, 3'd1,16'h1408,0);
    add(0,1,4'hF,0,0, 3'd2,16'h8000,0);

    do_reset("initial");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; enable = vecs[i].en; instr = vecs[i].op;
      flag_c = vecs[i].c; flag_z = vecs[i].z;
      #1;
      check($sformatf("row%0d step", i), 16'(step_e), 16'(vecs[i].exp_step));
      check($sformatf("row%0d word", i), word_e, vecs[i].exp_word);
      check($sformatf("row%0d halted", i), 16'(halt_e), 16'(vecs[i].exp_halt));
    end

    // Halted: frozen at T2 with HLT word whatever the opcode and flags
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      reset = 1'b0; enable = 1'b1; instr = 4'h1; flag_c = i[0]; flag_z = i[1];
      #1;
      check($sformatf("halt%0d step", i), 16'(step_e), 16'd2);
      check($sformatf("halt%0d word", i), word_e, 16'h8000);
      check($sformatf("halt%0d halted", i), 16'(halt_e), 16'd1);
    end
    do_reset("after halt");

    run_full("ADD full", 4'h2, 1'b0, 16'h4800, 16'h1020, 16'h0281);
    run_full("SUB full", 4'h3, 1'b0, 16'h4800, 16'h1020, 16'h02C1);
    run_full("JC full", 4'h7, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    run_full("LDA full", 4'h1, 1'b0, 16'h4800, 16'h1200, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
